pll_lock_reset_seq: RTL and testbench

Consumer side of the board PLL wrappers. Takes the PLL's asynchronous `locked` flag and turns it into a clean, held system reset for logic clocked by one PLL output. Requests a PLL reset pulse if lock never arrives. Counts lock-loss events for debug/status registers.

---
 rtl/pll_seq_pkg.sv | 27 ++
 rtl/sync_ff.sv | 26 ++
 rtl/pll_lock_reset_seq.sv | 128 ++++++++++++
 tb/tb_pll_lock_reset_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock / reset sequencer: state encodings
// and the helpers used to size its single shared timer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        HOLD      = 3'd2,
        RUN       = 3'd3,
        PLL_RST   = 3'd4
    } seq_state_e;

    // Bits needed to count from 0 up to n-1 (at least one bit).
    function automatic int unsigned timer_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) begin
            w++;
        end
        return w;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage flip-flop synchronizer for a single asynchronous level.
// STAGES must be at least 2. The flops carry the ASYNC_REG attribute so
// placement keeps them adjacent.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    // Shift the asynchronous level through the synchronizer chain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// Turns an asynchronous PLL lock flag into a qualified, held system reset,
// requests a PLL reset pulse when lock never arrives, and counts lock
// losses seen while running.
module pll_lock_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned PLLRST_CYCLES  = 32,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             locked_i,
    input  logic             clr_cnt_i,
    output logic             pll_rst_o,
    output logic             sys_rst_o,
    output logic             ready_o,
    output logic [CNT_W-1:0] loss_cnt_o,
    output logic [2:0]       state_o
);

    localparam int unsigned TMR_MAX = max2(max2(TIMEOUT_CYCLES, STABLE_CYCLES),
                                           max2(HOLD_CYCLES, PLLRST_CYCLES));
    localparam int unsigned TMR_W   = timer_width(TMR_MAX);

    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST    = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] PLLRST_LAST  = TMR_W'(PLLRST_CYCLES - 1);

    logic             lock_s;
    seq_state_e       state;
    seq_state_e       state_next;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_next;
    logic             loss_event;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] loss_next;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (locked_i),
        .q    (lock_s)
    );

    // Next-state, timer and loss-counter logic; the timer restarts on every state change.
    always_comb begin
        state_next = state;
        timer_next = timer + TMR_W'(1);
        loss_event = 1'b0;
        case (state)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_next = STABLE;
                end else if (timer == TIMEOUT_LAST) begin
                    state_next = PLL_RST;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                end else if (timer == STABLE_LAST) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                end else if (timer == HOLD_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                timer_next = timer;
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    loss_event = 1'b1;
                end
            end
            PLL_RST: begin
                if (timer == PLLRST_LAST) begin
                    state_next = WAIT_LOCK;
                end
            end
            default: begin
                state_next = WAIT_LOCK;
            end
        endcase
        if (state_next != state) begin
            timer_next = '0;
        end

        // A clear lands first, so a loss on the same cycle still counts once.
        cnt_base  = clr_cnt_i ? '0 : loss_cnt_o;
        loss_next = cnt_base;
        if (loss_event && (cnt_base != {CNT_W{1'b1}})) begin
            loss_next = cnt_base + CNT_W'(1);
        end
    end

    // State, timer and outputs, all decoded from the next state so they move together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= WAIT_LOCK;
            timer      <= '0;
            pll_rst_o  <= 1'b0;
            sys_rst_o  <= 1'b1;
            ready_o    <= 1'b0;
            loss_cnt_o <= '0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            pll_rst_o  <= (state_next == PLL_RST);
            sys_rst_o  <= (state_next != RUN);
            ready_o    <= (state_next == RUN);
            loss_cnt_o <= loss_next;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed testbench for pll_lock_reset_seq with small timing parameters.
module tb_pll_lock_reset_seq;

    logic       clk;
    logic       rstn;
    logic       locked_i;
    logic       clr_cnt_i;
    logic       pll_rst_o;
    logic       sys_rst_o;
    logic       ready_o;
    logic [1:0] loss_cnt_o;
    logic [2:0] state_o;

    int errors;
    int checks;
    int edge_n;

    pll_lock_reset_seq #(
        .SYNC_STAGES    (2),
        .STABLE_CYCLES  (8),
        .HOLD_CYCLES    (4),
        .TIMEOUT_CYCLES (64),
        .PLLRST_CYCLES  (4),
        .CNT_W          (2)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .locked_i   (locked_i),
        .clr_cnt_i  (clr_cnt_i),
        .pll_rst_o  (pll_rst_o),
        .sys_rst_o  (sys_rst_o),
        .ready_o    (ready_o),
        .loss_cnt_o (loss_cnt_o),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One clock edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Hold reset for a few cycles, release between edges; edge 1 is next.
    task automatic do_reset();
        rstn      = 1'b0;
        locked_i  = 1'b0;
        clr_cnt_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn   = 1'b1;
        edge_n = 0;
    endtask

    // Raise lock and wait (bounded) for RUN.
    task automatic reach_run();
        locked_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (state_o == 3'd3) break;
        end
        checks++;
        if (state_o !== 3'd3) begin
            errors++;
            $display("[TB] FAIL reach_run: state got %0d expected 3", state_o);
        end
    endtask

    // Drop lock in RUN; optionally pulse clr on the edge the loss registers.
    task automatic lose_lock(input logic [1:0] exp_cnt, input bit clr_at_loss);
        locked_i = 1'b0;
        step();
        checks++;
        if (sys_rst_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL loss_edge1_sysrst: got %0b expected 0", sys_rst_o);
        end
        step();
        checks++;
        if (state_o !== 3'd3) begin
            errors++;
            $display("[TB] FAIL loss_edge2_state: got %0d expected 3", state_o);
        end
        if (clr_at_loss) clr_cnt_i = 1'b1;
        step();
        clr_cnt_i = 1'b0;
        checks++;
        if (state_o !== 3'd0) begin
            errors++;
            $display("[TB] FAIL loss_state: got %0d expected 0", state_o);
        end
        checks++;
        if (sys_rst_o !== 1'b1 || ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL loss_outputs: sys_rst=%0b ready=%0b expected 1 0", sys_rst_o, ready_o);
        end
        checks++;
        if (loss_cnt_o !== exp_cnt) begin
            errors++;
            $display("[TB] FAIL loss_cnt: got %0d expected %0d", loss_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        locked_i  = 1'b0;
        clr_cnt_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (state_o !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %0d expected 0", state_o);
        end
        checks++;
        if (sys_rst_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_sys_rst: got %0b expected 1", sys_rst_o);
        end
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %0b expected 0", ready_o);
        end
        checks++;
        if (pll_rst_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_pll_rst: got %0b expected 0", pll_rst_o);
        end
        checks++;
        if (loss_cnt_o !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_loss_cnt: got %0d expected 0", loss_cnt_o);
        end
    endtask

    task automatic test_clean_lock();
        logic [2:0] exp_state;
        do_reset();
        locked_i = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            step();
            exp_state = (e < 3) ? 3'd0 : (e < 11) ? 3'd1 : (e < 15) ? 3'd2 : 3'd3;
            checks++;
            if (state_o !== exp_state) begin
                errors++;
                $display("[TB] FAIL clean_state@%0d: got %0d expected %0d", e, state_o, exp_state);
            end
            checks++;
            if (sys_rst_o !== (e < 15)) begin
                errors++;
                $display("[TB] FAIL clean_sys_rst@%0d: got %0b expected %0b", e, sys_rst_o, (e < 15));
            end
            checks++;
            if (ready_o !== (e >= 15)) begin
                errors++;
                $display("[TB] FAIL clean_ready@%0d: got %0b expected %0b", e, ready_o, (e >= 15));
            end
        end
    endtask

    task automatic test_no_lock();
        logic exp_pll;
        do_reset();
        for (int e = 1; e <= 140; e++) begin
            step();
            exp_pll = ((e >= 64) && (e <= 67)) || ((e >= 132) && (e <= 135));
            checks++;
            if (pll_rst_o !== exp_pll) begin
                errors++;
                $display("[TB] FAIL nolock_pll_rst@%0d: got %0b expected %0b", e, pll_rst_o, exp_pll);
            end
            checks++;
            if (state_o !== (exp_pll ? 3'd4 : 3'd0)) begin
                errors++;
                $display("[TB] FAIL nolock_state@%0d: got %0d expected %0d", e, state_o, (exp_pll ? 4 : 0));
            end
        end
    endtask

    task automatic test_glitch();
        logic [2:0] exp_state;
        do_reset();
        locked_i = 1'b1;
        for (int e = 1; e <= 23; e++) begin
            step();
            if (e == 5) locked_i = 1'b0;
            if (e == 8) locked_i = 1'b1;
            exp_state = (e < 3)  ? 3'd0 : (e < 8)  ? 3'd1 : (e < 11) ? 3'd0 :
                        (e < 19) ? 3'd1 : (e < 23) ? 3'd2 : 3'd3;
            checks++;
            if (state_o !== exp_state) begin
                errors++;
                $display("[TB] FAIL glitch_state@%0d: got %0d expected %0d", e, state_o, exp_state);
            end
        end
        checks++;
        if (ready_o !== 1'b1 || sys_rst_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_run_outputs: ready=%0b sys_rst=%0b expected 1 0", ready_o, sys_rst_o);
        end
        checks++;
        if (loss_cnt_o !== 2'd0) begin
            errors++;
            $display("[TB] FAIL glitch_loss_cnt: got %0d expected 0", loss_cnt_o);
        end
    endtask

    task automatic test_loss_in_run();
        do_reset();
        reach_run();
        lose_lock(2'd1, 1'b0);
    endtask

    task automatic test_saturation_clear();
        do_reset();
        reach_run(); lose_lock(2'd1, 1'b0);
        reach_run(); lose_lock(2'd2, 1'b0);
        reach_run(); lose_lock(2'd3, 1'b0);
        reach_run(); lose_lock(2'd3, 1'b0);
        reach_run(); lose_lock(2'd1, 1'b1);
        clr_cnt_i = 1'b1;
        step();
        clr_cnt_i = 1'b0;
        checks++;
        if (loss_cnt_o !== 2'd0) begin
            errors++;
            $display("[TB] FAIL clear_only: got %0d expected 0", loss_cnt_o);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (66) step();
        checks++;
        if (state_o !== 3'd4 || pll_rst_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_pre: state=%0d pll_rst=%0b expected 4 1", state_o, pll_rst_o);
        end
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if (pll_rst_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_pll_rst: got %0b expected 0", pll_rst_o);
        end
        checks++;
        if (sys_rst_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_sys_rst: got %0b expected 1", sys_rst_o);
        end
        @(negedge clk);
        rstn = 1'b1;
        step();
        checks++;
        if (state_o !== 3'd0 || pll_rst_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_after: state=%0d pll_rst=%0b expected 0 0", state_o, pll_rst_o);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        errors = 0;
        checks = 0;
        edge_n = 0;
        test_reset();
        test_clean_lock();
        test_no_lock();
        test_glitch();
        test_loss_in_run();
        test_saturation_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
